// File: rtl/serial_sub_if.sv
// Handshake bundle for serial_sub: operand channel (in_*, a, b) and result channel (out_*, diff, borrow, ovf).
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, out_ready,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, diff, borrow
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b computed LSB-first, one bit per clock, with a single borrow flip-flop.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  serial_sub_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res_q;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_c, out_valid_c;
  logic             accept, last_bit;
  logic             a_i, b_i, d, bout;

  assign a_i      = a_sh[0];
  assign b_i      = b_sh[0];
  assign d        = a_i ^ b_i ^ borrow_q;
  assign bout     = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_q);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign accept   = bus.in_valid & in_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Handshake outputs depend on the registered state only, never on in_valid/out_ready.
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Each RUN cycle consumes the operand LSBs and feeds the difference bit in at the result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      a_sh     <= bus.a;
      b_sh     <= bus.b;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      a_sh     <= a_sh >> 1;
      b_sh     <= b_sh >> 1;
      res_q    <= (res_q >> 1) | (WIDTH'(d) << (WIDTH - 1));
      borrow_q <= bout;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb, ovf_q;

  // The final difference bit is diff's MSB, so overflow is settled on the DONE transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (state_q == RUN && last_bit) begin
      ovf_q <= (a_msb ^ b_msb) & (d ^ a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.diff      = res_q;
  assign bus.borrow    = borrow_q;
endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub at WIDTH=8 and WIDTH=1 with hand-computed expected results.
// Overflow checks are compiled in only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  serial_sub_if #(.WIDTH(8)) bus8 ();
  serial_sub_if #(.WIDTH(1)) bus1 ();

  serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_sub #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Presents operands for one accept edge on the 8-bit unit, then drops in_valid.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
    checkOutput("in_ready_idle", 32'(bus8.in_ready), 32'd1);
    bus8.a = av;
    bus8.b = bv;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic waitResult8(inout int lat);
    while (!bus8.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runOp(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                       input logic eb, input logic eo, input int stall, input int junk);
    int lat;
    lat = 0;
    applyStimulus(av, bv);
    // Fresh operands offered during RUN must be ignored.
    for (int i = 0; i < junk; i++) begin
      bus8.a = ~av;
      bus8.b = 8'h00;
      bus8.in_valid = 1'b1;
      checkOutput("in_ready_run", 32'(bus8.in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    bus8.in_valid = 1'b0;
    waitResult8(lat);
    checkOutput("latency", 32'(lat), 32'd8);
    checkOutput("diff", 32'(bus8.diff), 32'(ed));
    checkOutput("borrow", 32'(bus8.borrow), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("ovf", 32'(bus8.ovf), 32'(eo));
`else
    if (eo !== eo) checkOutput("ovf_unused", 32'd0, 32'd0);
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_valid", 32'(bus8.out_valid), 32'd1);
      checkOutput("stall_in_ready", 32'(bus8.in_ready), 32'd0);
      checkOutput("stall_diff", 32'(bus8.diff), 32'(ed));
      checkOutput("stall_borrow", 32'(bus8.borrow), 32'(eb));
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    checkOutput("post_hs_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("post_hs_in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("post_hs_diff_kept", 32'(bus8.diff), 32'(ed));
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0;
    #2;
    checkOutput("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("rst_diff", 32'(bus8.diff), 32'd0);
    checkOutput("rst_borrow", 32'(bus8.borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("rst_ovf", 32'(bus8.ovf), 32'd0);
`endif
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic subtraction vectors");
    runOp(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, 0);
    runOp(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0, 0);
    runOp(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 0);

    $display("[TB] equal operands with stalled consumer");
    runOp(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 5, 0);

    $display("[TB] reset during RUN");
    applyStimulus(8'h10, 8'h01);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrun_in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("midrun_out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("midrun_diff", 32'(bus8.diff), 32'd0);
    checkOutput("midrun_borrow", 32'(bus8.borrow), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    runOp(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 0, 0);

    $display("[TB] operands offered during RUN");
    runOp(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 0, 3);

    $display("[TB] single-bit unit");
    checkOutput("w1_in_ready", 32'(bus1.in_ready), 32'd1);
    bus1.a = 1'b0;
    bus1.b = 1'b1;
    bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("w1_latency", 32'(lat), 32'd1);
    checkOutput("w1_diff", 32'(bus1.diff), 32'd1);
    checkOutput("w1_borrow", 32'(bus1.borrow), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("w1_ovf", 32'(bus1.ovf), 32'd1);
`endif
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    checkOutput("w1_post_hs_in_ready", 32'(bus1.in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
